stk_pipe_wrbk_q: RTL



---
 rtl/stk_pkg.sv | 32 +++
 rtl/stk_rsp_fifo.sv | 47 ++++
 rtl/stk_pipe_wrbk_q.sv | 104 ++++++++++
 3 files changed

// File: rtl/stk_pkg.sv
// Shared types for the stk pipeline: engine id, response status and the
// response-queue entry, plus the engine-id decoder.
package stk_pkg;

   localparam int STK_ENGS_N = 3;
   localparam int STK_RSPQ_N = 4;
   localparam int STK_DAT_W  = 128;
   localparam int ENGID_W    = 2;

   typedef logic [ENGID_W-1:0] engid_t;

   typedef enum logic [1:0] {
      STS_OK    = 2'd0,
      STS_ERR   = 2'd1,
      STS_RETRY = 2'd2,
      STS_FAULT = 2'd3
   } status_t;

   typedef struct packed {
      status_t      status;
      logic [127:0] dat;
   } stk_rsp_t;

   // One-hot decode across the whole engid space; callers mask to ENGS_N.
   function automatic logic [(1<<ENGID_W)-1:0] dec(input engid_t id);
      logic [(1<<ENGID_W)-1:0] onehot;
      onehot     = '0;
      onehot[id] = 1'b1;
      return onehot;
   endfunction

endpackage

// File: rtl/stk_rsp_fifo.sv
// Single-engine synchronous response FIFO; registered head, no bypass.
module stk_rsp_fifo
   import stk_pkg::*;
#(
   parameter  int W     = 8,
   parameter  int N     = 4,
   localparam int PTR_W = $clog2(N),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     push_dat,
   input  logic             pop,
   output logic [W-1:0]     head_dat,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   logic [W-1:0]     mem [N];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointers wrap naturally; the caller never pushes when full or pops when empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(N));

endmodule

// File: rtl/stk_pipe_wrbk_q.sv
// Queued writeback stage: steers each microcode writeback into a per-engine
// response FIFO. Define STK_PIPE_WRBK_OCC_EN to expose occupancy and high-water marks.
module stk_pipe_wrbk_q
   import stk_pkg::*;
#(
   parameter  int ENGS_N = STK_ENGS_N,
   parameter  int DAT_W  = STK_DAT_W,
   parameter  int RSPQ_N = STK_RSPQ_N,
   localparam int CNT_W  = $clog2(RSPQ_N) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_wrbk_uc_vld_r,
   input  engid_t                  i_wrbk_uc_engid_r,
   input  status_t                 i_wrbk_uc_status_r,
   input  logic [DAT_W-1:0]        i_wrbk_uc_dat_r,
   output logic                    o_wrbk_uc_stall,
   output logic [ENGS_N-1:0]       o_rsp_vld,
   input  logic [ENGS_N-1:0]       i_rsp_accept,
   output logic [ENGS_N*DAT_W-1:0] o_rsp_dat,
   output status_t                 o_rsp_status [ENGS_N],
   output logic                    o_err_engid_r
`ifdef STK_PIPE_WRBK_OCC_EN
   ,
   output logic [ENGS_N-1:0][CNT_W-1:0] o_rsp_occ,
   output logic [ENGS_N-1:0][CNT_W-1:0] o_rsp_hwm_r
`endif
);

   logic [(1<<ENGID_W)-1:0]       sel;
   logic                          sel_unused;
   logic                          in_range;
   logic [ENGS_N-1:0]             push;
   logic [ENGS_N-1:0]             pop;
   logic [ENGS_N-1:0]             empty;
   logic [ENGS_N-1:0]             full;
   logic [ENGS_N-1:0][CNT_W-1:0] count;
   stk_rsp_t                      wr_ent;

   assign sel        = dec(i_wrbk_uc_engid_r);
   assign sel_unused = ^sel;
   assign in_range   = (32'(i_wrbk_uc_engid_r) < ENGS_N);
   assign wr_ent     = '{status: i_wrbk_uc_status_r, dat: 128'(i_wrbk_uc_dat_r)};

   // Stall looks only at registered full; a same-cycle pop does not release it.
   assign o_wrbk_uc_stall = i_wrbk_uc_vld_r & |(sel[ENGS_N-1:0] & full);

   for (genvar e = 0; e < ENGS_N; e++) begin : g_eng
      stk_rsp_t head_ent;

      assign push[e] = i_wrbk_uc_vld_r & sel[e] & ~full[e];
      assign pop[e]  = ~empty[e] & i_rsp_accept[e];

      stk_rsp_fifo #(
         .W ($bits(stk_rsp_t)),
         .N (RSPQ_N)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .push     (push[e]),
         .push_dat (wr_ent),
         .pop      (pop[e]),
         .head_dat (head_ent),
         .empty    (empty[e]),
         .full     (full[e]),
         .count    (count[e])
      );

      assign o_rsp_vld[e]                  = ~empty[e];
      assign o_rsp_dat[e*DAT_W +: DAT_W]   = head_ent.dat[DAT_W-1:0];
      assign o_rsp_status[e]               = head_ent.status;
   end

   // Out-of-range writebacks are dropped silently but leave a sticky flag.
   always_ff @(posedge clk) begin
      if (rst)                                o_err_engid_r <= 1'b0;
      else if (i_wrbk_uc_vld_r && !in_range)  o_err_engid_r <= 1'b1;
   end

`ifdef STK_PIPE_WRBK_OCC_EN
   logic [ENGS_N-1:0][CNT_W-1:0] count_next;

   assign o_rsp_occ = count;

   always_comb begin
      count_next = count;
      for (int e = 0; e < ENGS_N; e++) begin
         if (push[e] && !pop[e])      count_next[e] = count[e] + 1'b1;
         else if (pop[e] && !push[e]) count_next[e] = count[e] - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_rsp_hwm_r <= '0;
      end else begin
         for (int e = 0; e < ENGS_N; e++) begin
            if (count_next[e] > o_rsp_hwm_r[e]) o_rsp_hwm_r[e] <= count_next[e];
         end
      end
   end
`endif

endmodule
